// File: rtl/sm_reg_scan.sv
// sm_reg_scan: sequencer for the core's single debug register-read port.
// Manual mode follows a selected address with periodic refresh; auto mode
// scans FIRST_REG..LAST_REG with a programmable dwell per register. Each read
// is captured into a registered address/value pair for the display path.
module sm_reg_scan #(
    parameter int unsigned DWELL_CYCLES = 50000000,
    parameter int unsigned FIRST_REG    = 0,
    parameter int unsigned LAST_REG     = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode_auto,
    input  logic        hold,
    input  logic        step,
    input  logic [4:0]  manual_addr,
    output logic [4:0]  reg_addr,
    input  logic [31:0] reg_data,
    output logic [4:0]  disp_addr,
    output logic [31:0] disp_data,
    output logic        disp_valid,
    output logic        scan_active
);

    localparam int unsigned CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [4:0]    FIRST_A  = 5'(FIRST_REG);
    localparam logic [4:0]    SPAN     = 5'(LAST_REG - FIRST_REG);

    localparam logic [1:0] S_SET    = 2'd0;
    localparam logic [1:0] S_SAMPLE = 2'd1;
    localparam logic [1:0] S_DWELL  = 2'd2;

    logic        mode_s1_q, mode_s2_q;
    logic        hold_s1_q, hold_s2_q;
    logic        step_s1_q, step_s2_q, step_prev_q;
    logic [4:0]  maddr_s1_q, maddr_s2_q;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    reg_addr_q, reg_addr_d;
    logic [4:0]    disp_addr_q, disp_addr_d;
    logic [31:0]   disp_data_q, disp_data_d;
    logic          disp_valid_q, disp_valid_d;
    logic          scan_active_q, scan_active_d;

    logic          step_rise;
    logic          terminal;
    logic [4:0]    addr_off;
    logic [4:0]    next_addr;

    assign step_rise = step_s2_q & ~step_prev_q;
    assign terminal  = (cnt_q == '0) && !hold_s2_q;

    // Offset from FIRST_REG wraps modulo 32, so an address below the range
    // lands above SPAN and is treated like the end of the range.
    assign addr_off  = reg_addr_q - FIRST_A;
    assign next_addr = (addr_off < SPAN) ? reg_addr_q + 5'd1 : FIRST_A;

    // Two-flop synchronisers for the asynchronous board inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1_q   <= 1'b0;
            mode_s2_q   <= 1'b0;
            hold_s1_q   <= 1'b0;
            hold_s2_q   <= 1'b0;
            step_s1_q   <= 1'b0;
            step_s2_q   <= 1'b0;
            step_prev_q <= 1'b0;
            maddr_s1_q  <= '0;
            maddr_s2_q  <= '0;
        end else begin
            mode_s1_q   <= mode_auto;
            mode_s2_q   <= mode_s1_q;
            hold_s1_q   <= hold;
            hold_s2_q   <= hold_s1_q;
            step_s1_q   <= step;
            step_s2_q   <= step_s1_q;
            step_prev_q <= step_s2_q;
            maddr_s1_q  <= manual_addr;
            maddr_s2_q  <= maddr_s1_q;
        end
    end

    // Sequencer next-state: mode change, then manual retarget, then the set/sample/dwell cycle
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        reg_addr_d    = reg_addr_q;
        disp_addr_d   = disp_addr_q;
        disp_data_d   = disp_data_q;
        disp_valid_d  = 1'b0;
        scan_active_d = scan_active_q;

        if (mode_s2_q != scan_active_q) begin
            scan_active_d = mode_s2_q;
            state_d       = S_SET;
            if (!mode_s2_q) begin
                reg_addr_d = maddr_s2_q;
            end
        end else if (!scan_active_q && (maddr_s2_q != reg_addr_q)) begin
            reg_addr_d = maddr_s2_q;
            state_d    = S_SET;
        end else begin
            case (state_q)
                S_SET: begin
                    state_d = S_SAMPLE;
                end
                S_SAMPLE: begin
                    disp_data_d  = reg_data;
                    disp_addr_d  = reg_addr_q;
                    disp_valid_d = 1'b1;
                    cnt_d        = CNT_LOAD;
                    state_d      = S_DWELL;
                end
                S_DWELL: begin
                    if (!hold_s2_q && (cnt_q != '0)) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                    if (scan_active_q) begin
                        if (terminal || step_rise) begin
                            reg_addr_d = next_addr;
                            state_d    = S_SET;
                        end
                    end else if (terminal) begin
                        state_d = S_SET;
                    end
                end
                default: begin
                    state_d = S_SET;
                end
            endcase
        end
    end

    // Sequencer state and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_SET;
            cnt_q         <= '0;
            reg_addr_q    <= FIRST_A;
            disp_addr_q   <= FIRST_A;
            disp_data_q   <= '0;
            disp_valid_q  <= 1'b0;
            scan_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            reg_addr_q    <= reg_addr_d;
            disp_addr_q   <= disp_addr_d;
            disp_data_q   <= disp_data_d;
            disp_valid_q  <= disp_valid_d;
            scan_active_q <= scan_active_d;
        end
    end

    assign reg_addr    = reg_addr_q;
    assign disp_addr   = disp_addr_q;
    assign disp_data   = disp_data_q;
    assign disp_valid  = disp_valid_q;
    assign scan_active = scan_active_q;

endmodule

// File: tb/tb_sm_reg_scan.sv
// Testbench for sm_reg_scan: directed scenarios plus random stimulus, all
// outputs compared every cycle against a behavioural reference model.
module tb_sm_reg_scan;

    localparam int DW    = 4;
    localparam int FIRST = 0;
    localparam int LAST  = 3;

    logic        clk;
    logic        rst_n;
    logic        mode_auto;
    logic        hold;
    logic        step;
    logic [4:0]  manual_addr;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [4:0]  disp_addr;
    logic [31:0] disp_data;
    logic        disp_valid;
    logic        scan_active;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    sm_reg_scan #(
        .DWELL_CYCLES(DW),
        .FIRST_REG   (FIRST),
        .LAST_REG    (LAST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_auto  (mode_auto),
        .hold       (hold),
        .step       (step),
        .manual_addr(manual_addr),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .scan_active(scan_active)
    );

    // Core debug port model: combinational read data
    assign reg_data = 32'h1000 + {27'd0, reg_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Input history: index 0 = value seen at last edge, 1 = the edge before.
    bit     h_mode[2];
    bit     h_hold[2];
    bit     h_step[2];
    int     h_maddr[2];
    bit     m_step_seen;   // synced step as of previous edge
    int     m_phase;       // 0 settle, 1 capture, 2 dwell
    int     m_used;        // unheld dwell cycles already spent
    int     m_addr;
    int     m_daddr;
    int     m_ddata;
    bit     m_valid;
    bit     m_active;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            h_mode[i] = 0; h_hold[i] = 0; h_step[i] = 0; h_maddr[i] = 0;
        end
        m_step_seen = 0;
        m_phase = 0; m_used = 0;
        m_addr = FIRST; m_daddr = FIRST; m_ddata = 0;
        m_valid = 0; m_active = 0;
    endtask

    function automatic int advance(input int a);
        if (a >= FIRST && a < LAST) return a + 1;
        return FIRST;
    endfunction

    task automatic model_step();
        bit s_mode, s_hold, s_step, rise, term;
        int s_maddr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s_mode  = h_mode[1];
        s_hold  = h_hold[1];
        s_step  = h_step[1];
        s_maddr = h_maddr[1];
        rise    = s_step && !m_step_seen;
        term    = 0;
        m_valid = 0;
        if (s_mode != m_active) begin
            m_active = s_mode;
            m_phase  = 0;
            if (!s_mode) m_addr = s_maddr;
        end else if (!m_active && s_maddr != m_addr) begin
            m_addr  = s_maddr;
            m_phase = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_daddr = m_addr;
            m_ddata = 32'h1000 + m_addr;
            m_valid = 1;
            m_used  = 0;
            m_phase = 2;
        end else begin
            if (!s_hold) begin
                if (m_used == DW - 1) term = 1;
                else m_used++;
            end
            if (m_active && (term || rise)) begin
                m_addr  = advance(m_addr);
                m_phase = 0;
            end else if (!m_active && term) begin
                m_phase = 0;
            end
        end
        m_step_seen = s_step;
        h_mode[1] = h_mode[0];   h_mode[0] = mode_auto;
        h_hold[1] = h_hold[0];   h_hold[0] = hold;
        h_step[1] = h_step[0];   h_step[0] = step;
        h_maddr[1] = h_maddr[0]; h_maddr[0] = int'(manual_addr);
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    task automatic compare_all();
        chk("reg_addr",    32'(reg_addr),    32'(m_addr));
        chk("disp_addr",   32'(disp_addr),   32'(m_daddr));
        chk("disp_data",   disp_data,        32'(m_ddata));
        chk("disp_valid",  32'(disp_valid),  32'(m_valid));
        chk("scan_active", 32'(scan_active), 32'(m_active));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        cyc_n++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(input int maxc, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (disp_valid === 1'b1) begin
                ok = 1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic pulse_step(input int hi, input int lo);
        step = 1'b1;
        ticks(hi);
        step = 1'b0;
        ticks(lo);
    endtask

    // ---------------- stimulus ----------------
    int   cap_addr[6];
    int   cap_data[6];
    int   cap_cyc[6];
    int   ncap;
    int   exp_seq[6];
    int   cnt;
    logic [4:0] a0;

    initial begin
        exp_seq = '{0, 0, 1, 2, 3, 0};
        rst_n = 1'b0; mode_auto = 1'b1; hold = 1'b0; step = 1'b0; manual_addr = 5'd0;
        model_reset();
        #1;
        chk("rst_reg_addr",   32'(reg_addr),   32'(FIRST));
        chk("rst_disp_valid", 32'(disp_valid), 32'd0);
        chk("rst_disp_data",  disp_data,       32'd0);
        chk("rst_scan",       32'(scan_active), 32'd0);
        ticks(3);
        rst_n = 1'b1;

        // Auto scan from reset: capture sequence, data and cadence
        ncap = 0;
        for (int i = 0; i < 60 && ncap < 6; i++) begin
            tick();
            if (disp_valid === 1'b1) begin
                cap_addr[ncap] = int'(disp_addr);
                cap_data[ncap] = int'(disp_data);
                cap_cyc[ncap]  = cyc_n;
                ncap++;
            end
        end
        chk("p1_captures", 32'(ncap), 32'd6);
        for (int i = 0; i < ncap; i++) begin
            chk("p1_addr", 32'(cap_addr[i]), 32'(exp_seq[i]));
            chk("p1_data", 32'(cap_data[i]), 32'h1000 + 32'(exp_seq[i]));
            if (i >= 2) chk("p1_period", 32'(cap_cyc[i] - cap_cyc[i-1]), 32'd6);
        end

        // Hold freezes the dwell; step still advances
        hold = 1'b1;
        ticks(4);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (disp_valid === 1'b1) cnt++;
        end
        chk("hold_no_valid", 32'(cnt), 32'd0);
        a0 = disp_addr;
        pulse_step(3, 6);
        pulse_step(3, 6);
        chk("hold_step2", 32'(disp_addr), 32'((int'(a0) + 2) % 4));
        hold = 1'b0;
        ticks(20);

        // Manual mode: follow address 7, then retarget to 12 mid-dwell
        mode_auto = 1'b0;
        manual_addr = 5'd7;
        ticks(14);
        chk("man_addr7", 32'(disp_addr), 32'd7);
        chk("man_data7", disp_data,      32'h1007);
        wait_valid(8, "man_refresh");
        ticks(2);
        manual_addr = 5'd12;
        cnt = 0;
        for (int i = 0; i < 10 && disp_addr !== 5'd12; i++) begin
            tick();
            cnt++;
        end
        chk("man_retarget_lat", 32'(cnt <= 5), 32'd1);
        chk("man_data12", disp_data, 32'h100C);

        // Step ignored in manual mode
        pulse_step(3, 10);
        chk("man_step_ignored", 32'(disp_addr), 32'd12);

        // Manual to auto at 12: capture 12 then out-of-range reload to FIRST
        mode_auto = 1'b1;
        wait_valid(12, "m2a_first");
        chk("m2a_addr12", 32'(disp_addr), 32'd12);
        wait_valid(12, "m2a_second");
        chk("m2a_reload", 32'(disp_addr), 32'(FIRST));

        // Step rise lands on the dwell terminal edge: exactly one advance
        wait_valid(12, "term_sync");
        a0 = disp_addr;
        tick();
        pulse_step(3, 0);
        wait_valid(8, "term_step_cap");
        chk("term_step_single", 32'(disp_addr), 32'((int'(a0) + 1) % 4));

        // Reset pulse mid-dwell at address 2
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (disp_valid === 1'b1 && disp_addr === 5'd2) begin
                cnt = 1;
                break;
            end
        end
        chk("reach_addr2", 32'(cnt), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_reg_addr",  32'(reg_addr),   32'(FIRST));
        chk("mid_rst_disp_addr", 32'(disp_addr),  32'(FIRST));
        chk("mid_rst_disp_data", disp_data,       32'd0);
        chk("mid_rst_valid",     32'(disp_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        ticks(2);
        chk("post_rst_valid", 32'(disp_valid), 32'd1);
        chk("post_rst_addr",  32'(disp_addr),  32'(FIRST));
        chk("post_rst_data",  disp_data,       32'h1000);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) mode_auto = ~mode_auto;
            if ($urandom_range(0, 7) == 0)  hold = ~hold;
            if ($urandom_range(0, 3) == 0)  step = ~step;
            if ($urandom_range(0, 31) == 0) manual_addr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sm_reg_scan.md
Name: sm_reg_scan

Overview:
- Scheduler for the single debug register-read port of the CPU core (regAddr in, regData out).
- Replaces direct DIP-switch addressing with a sequencer: manual mode follows a selected address; auto mode scans a register range with a programmable dwell time.
- Captures each read into a stable, registered value/address pair for the LED and 7-segment display path.
- Sits in the board top between the GPIO/DIP/KEY inputs, the core's debug port, and the hex display logic.

Parameters:
- DWELL_CYCLES, 50000000: cycles each register is held in auto mode; also the manual refresh period; must be >= 1.
- FIRST_REG, 0: first register of the auto-scan range.
- LAST_REG, 31: last register of the auto-scan range; LAST_REG >= FIRST_REG, both <= 31.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mode_auto  in  1  1 = auto scan, 0 = manual; asynchronous, synchronised internally
- hold  in  1  1 = freeze the dwell timer; asynchronous, synchronised internally
- step  in  1  advance request, active-high level; rising edge detected after synchronisation
- manual_addr  in  5  manual register select; asynchronous, synchronised internally
- reg_addr  out  5  address driven to the core debug port
- reg_data  in  32  combinational read data from the core for reg_addr
- disp_addr  out  5  address of the captured value
- disp_data  out  32  captured register value
- disp_valid  out  1  one-cycle strobe when disp_data/disp_addr update
- scan_active  out  1  1 while the synchronised mode is auto

Behaviour:
- Synchronisers: mode_auto, hold, step and manual_addr each pass through 2 flops (2-cycle latency). step_rise = synced step & ~previous synced step.
- Reset values: reg_addr = FIRST_REG, disp_addr = FIRST_REG, disp_data = 0, disp_valid = 0, scan_active = 0, dwell counter = 0, synchroniser flops = 0, state = S_SET.
- S_SET: reg_addr is stable for this cycle so the core read settles; next state is S_SAMPLE.
- S_SAMPLE: disp_data <= reg_data, disp_addr <= reg_addr, disp_valid = 1 for this cycle only; counter <= DWELL_CYCLES-1; next state is S_DWELL.
- S_DWELL: the counter decrements each cycle while hold = 0 and holds while hold = 1. Terminal condition is counter == 0 with hold = 0.
- Auto mode, terminal or step_rise: reg_addr <= (reg_addr == LAST_REG) ? FIRST_REG : reg_addr + 1; go to S_SET.
- Manual mode, terminal: reg_addr is unchanged; go to S_SET (periodic refresh).
- Manual mode, synced manual_addr != reg_addr: reg_addr <= manual_addr; go to S_SET immediately, regardless of hold or counter value.
- step_rise is ignored in manual mode.
- Auto-mode period per register: DWELL_CYCLES + 2 cycles (1 S_SET + 1 S_SAMPLE + DWELL_CYCLES in S_DWELL) when hold = 0.
- Simultaneous terminal and step_rise: exactly one advance.
- step_rise while hold = 1 in auto mode: advances; hold only blocks the timer.
- step_rise in S_SET or S_SAMPLE: dropped.
- Mode change, from any state, takes effect in the cycle the synced mode differs from scan_active:
  - scan_active <= new mode; go to S_SET.
  - Auto to manual: reg_addr <= synced manual_addr.
  - Manual to auto: reg_addr is unchanged; the scan resumes from the current address.
- Auto mode with reg_addr outside [FIRST_REG, LAST_REG] (possible after leaving manual mode): the next advance loads FIRST_REG.
- Reset asserted mid-operation: all state returns to reset values asynchronously; after release, the first disp_valid occurs 2 cycles later with disp_addr = FIRST_REG.
- Counter width: clog2(DWELL_CYCLES), minimum 1 bit.

Test Plan:
All tests use DWELL_CYCLES = 4, FIRST_REG = 0, LAST_REG = 3; the core model returns reg_data = 0x1000 + addr.
- Reset release, mode_auto = 1 held → disp_valid pulses every 6 cycles; disp_addr sequence is 0, 1, 2, 3, 0 with disp_data 0x1000, 0x1001, 0x1002, 0x1003, 0x1000 (wrap check).
- Auto mode, hold = 1 from cycle 10 → no further disp_valid; step pulsed 3 cycles high, twice → disp_addr advances by exactly 2; hold = 0 → the 6-cycle cadence resumes.
- Manual mode with manual_addr = 7 → disp_addr = 7, disp_data = 0x1007, refreshed every 6 cycles. Change manual_addr to 12 mid-dwell → disp_addr = 12 within 5 cycles of the change (2 sync + SET + SAMPLE + 1).
- Manual to auto at reg_addr = 12 → the next capture shows 12; the following advance shows 0 (out-of-range reload).
- step rising edge on the same cycle as the dwell terminal → single increment only; step pulse in manual mode → no address change.
- rst_n low for 1 cycle mid-dwell at addr 2 → outputs return to reset values immediately; first post-reset disp_valid shows disp_addr = 0, disp_data = 0x1000.
